// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if
//   Bundles the three sram-like links around the arbiter: the instruction
//   requester, the data requester and the shared downstream bus port.
//   Handshake: a requester holds req and its fields until the cycle in which
//   addr_ok is high (that cycle is the transfer). data_ok is a one-cycle pulse
//   with rdata valid in the same cycle, and it has no back-pressure. The bus
//   side uses the same rules, with the arbiter as the requester.
//   Modports:
//     slave  - arbiter view: requester signals in, bus request out
//     master - environment view (pipeline plus bus bridge): the reverse
interface sram_req_arbiter_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport slave (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
        input  data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
        output data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one sram-like bus port between the instruction requester and the
//   data requester. Address phases are granted with a fixed priority.
//   Once a grant has been offered on the bus it stays locked until the bus
//   accepts it. Every accepted transaction pushes an owner tag
//   (0 = inst, 1 = data) into a small FIFO. In-order bus responses pop that
//   FIFO and are steered to the owner. addr_ok and data_ok pass through
//   combinationally, so the arbiter adds no latency.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     sif             requester and bus links (slave modport)
//     dbg_lock_state  lock FSM state (0 = unlocked, 1 = inst, 2 = data)
//     dbg_count       outstanding transaction count
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,    // 1..4
    parameter bit DATA_PRIO       = 1'b1  // 1: data wins a tie
) (
    input  logic               clk,
    input  logic               reset,
    sram_req_arbiter_if.slave  sif,
    output logic [1:0]         dbg_lock_state,
    output logic [2:0]         dbg_count
);
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

    lock_state_t state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]  tag_q;

    logic lock_v, grant, head_tag, pop, push, full, bus_req_int;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    // A stray response (nothing outstanding) is ignored entirely.
    assign pop      = !reset && sif.bus_data_ok && (count_q != 3'd0);
    assign head_tag = tag_q[rd_ptr_q];
    // A pop in this cycle frees its slot before the push is considered.
    assign full     = (count_q == MAX_CNT) && !pop;
    assign lock_v   = (state_q != LOCK_NONE);

    always_comb begin
        grant = 1'b0;
        if (lock_v) begin
            grant = (state_q == LOCK_DATA);
        end else if (DATA_PRIO) begin
            grant = sif.data_sram_req;
        end else begin
            grant = !sif.inst_sram_req;
        end
    end

    assign bus_req_int = !reset && !full &&
                         (lock_v || sif.inst_sram_req || sif.data_sram_req);
    assign push        = bus_req_int && sif.bus_addr_ok;

    // Lock FSM: an offered but unaccepted grant is pinned; while full,
    // no request is offered, so the lock simply holds.
    always_comb begin
        state_d = state_q;
        if (push) begin
            state_d = LOCK_NONE;
        end else if (bus_req_int) begin
            state_d = grant ? LOCK_DATA : LOCK_INST;
        end
    end

    assign count_d = count_q + 3'(push) - 3'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOCK_NONE;
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            tag_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                tag_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
        end
    end

    // Bus fields are zero whenever no request is offered.
    always_comb begin
        sif.bus_wr    = 1'b0;
        sif.bus_size  = 2'd0;
        sif.bus_addr  = 32'd0;
        sif.bus_wstrb = 4'd0;
        sif.bus_wdata = 32'd0;
        if (bus_req_int) begin
            if (grant) begin
                sif.bus_wr    = sif.data_sram_wr;
                sif.bus_size  = sif.data_sram_size;
                sif.bus_addr  = sif.data_sram_addr;
                sif.bus_wstrb = sif.data_sram_wr ? sif.data_sram_wstrb : 4'd0;
                sif.bus_wdata = sif.data_sram_wdata;
            end else begin
                sif.bus_size  = 2'd2;
                sif.bus_addr  = sif.inst_sram_addr;
            end
        end
    end

    assign sif.bus_req           = bus_req_int;
    assign sif.inst_sram_addr_ok = push && !grant;
    assign sif.data_sram_addr_ok = push && grant;
    assign sif.inst_sram_data_ok = pop && !head_tag;
    assign sif.data_sram_data_ok = pop && head_tag;
    assign sif.inst_sram_rdata   = reset ? 32'd0 : sif.bus_rdata;
    assign sif.data_sram_rdata   = reset ? 32'd0 : sif.bus_rdata;

    assign dbg_lock_state = state_q;
    assign dbg_count      = count_q;
endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;
    localparam int MAX = 2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_lock_state;
    logic [2:0] dbg_count;

    sram_req_arbiter_if sif();

    sram_req_arbiter #(.MAX_OUTSTANDING(MAX), .DATA_PRIO(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .sif            (sif),
        .dbg_lock_state (dbg_lock_state),
        .dbg_count      (dbg_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [0:0] exp_q[$];      // owner tags of accepted, unanswered transactions
    int         pend_owner;    // requester whose offer is pinned, -1 if none
    logic       inst_acc, data_acc;

    logic        obs_inst_aok, obs_data_aok, obs_inst_dok, obs_data_dok, obs_bus_req;
    logic [31:0] obs_inst_rdata, obs_bus_addr;
    logic [3:0]  obs_bus_wstrb;
    logic [2:0]  obs_count;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        sif.inst_sram_req   = 1'b0;
        sif.inst_sram_addr  = 32'd0;
        sif.data_sram_req   = 1'b0;
        sif.data_sram_wr    = 1'b0;
        sif.data_sram_size  = 2'd0;
        sif.data_sram_addr  = 32'd0;
        sif.data_sram_wstrb = 4'd0;
        sif.data_sram_wdata = 32'd0;
        sif.bus_addr_ok     = 1'b0;
        sif.bus_data_ok     = 1'b0;
        sif.bus_rdata       = 32'd0;
    endtask

    // Inputs are driven at the negedge; this settles, compares against the
    // reference model, advances the model and returns at the next negedge.
    task automatic run_cycle();
        int         who;
        logic       pop_ok, room, exp_req, acc;
        logic [70:0] exp_fields;
        #1;
        obs_inst_aok   = sif.inst_sram_addr_ok;
        obs_data_aok   = sif.data_sram_addr_ok;
        obs_inst_dok   = sif.inst_sram_data_ok;
        obs_data_dok   = sif.data_sram_data_ok;
        obs_inst_rdata = sif.inst_sram_rdata;
        obs_bus_req    = sif.bus_req;
        obs_bus_addr   = sif.bus_addr;
        obs_bus_wstrb  = sif.bus_wstrb;
        obs_count      = dbg_count;
        inst_acc = 1'b0;
        data_acc = 1'b0;
        if (reset) begin
            check("rst_bus", 128'({sif.bus_req, sif.bus_wr, sif.bus_size, sif.bus_addr,
                                   sif.bus_wstrb, sif.bus_wdata}), 128'd0);
            check("rst_req_side", 128'({sif.inst_sram_addr_ok, sif.data_sram_addr_ok,
                                        sif.inst_sram_data_ok, sif.data_sram_data_ok,
                                        sif.inst_sram_rdata, sif.data_sram_rdata}), 128'd0);
            exp_q.delete();
            pend_owner = -1;
        end else begin
            pop_ok = sif.bus_data_ok && (exp_q.size() > 0);
            room   = (exp_q.size() - (pop_ok ? 1 : 0)) < MAX;
            if (pend_owner >= 0)                             who = pend_owner;
            else if (sif.data_sram_req)                      who = 1;
            else if (sif.inst_sram_req)                      who = 0;
            else                                             who = -1;
            exp_req = (who >= 0) && room;
            acc     = exp_req && sif.bus_addr_ok;

            check("bus_req", 128'(sif.bus_req), 128'(exp_req));
            if (exp_req) begin
                if (who == 1)
                    exp_fields = {sif.data_sram_wr, sif.data_sram_size, sif.data_sram_addr,
                                  sif.data_sram_wr ? sif.data_sram_wstrb : 4'd0,
                                  sif.data_sram_wdata};
                else
                    exp_fields = {1'b0, 2'd2, sif.inst_sram_addr, 4'd0, 32'd0};
                check("bus_fields", 128'({sif.bus_wr, sif.bus_size, sif.bus_addr,
                                          sif.bus_wstrb, sif.bus_wdata}), 128'(exp_fields));
            end
            check("addr_ok", 128'({sif.inst_sram_addr_ok, sif.data_sram_addr_ok}),
                  128'({acc && who == 0, acc && who == 1}));
            check("data_ok", 128'({sif.inst_sram_data_ok, sif.data_sram_data_ok}),
                  128'({pop_ok && exp_q[0] == 1'b0, pop_ok && exp_q[0] == 1'b1}));
            if (pop_ok)
                check("rdata", 128'({sif.inst_sram_rdata, sif.data_sram_rdata}),
                      128'({sif.bus_rdata, sif.bus_rdata}));
            check("count", 128'(dbg_count), 128'(exp_q.size()));
            check("lock", 128'(dbg_lock_state != 2'd0), 128'(pend_owner >= 0));

            if (pop_ok) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(1'(who));
                pend_owner = -1;
            end else if (exp_req) begin
                pend_owner = who;
            end
            inst_acc = acc && (who == 0);
            data_acc = acc && (who == 1);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic inst_busy, data_busy;

    initial begin
        pend_owner = -1;
        inst_busy  = 1'b0;
        data_busy  = 1'b0;
        idle_inputs();
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();
        check("reset_bus_req", 128'(obs_bus_req), 128'd0);
        check("reset_count", 128'(obs_count), 128'd0);

        // Single inst read.
        sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_0000; sif.bus_addr_ok = 1'b1;
        run_cycle();
        check("s1_inst_aok", 128'(obs_inst_aok), 128'd1);
        check("s1_bus_addr", 128'(obs_bus_addr), 128'h1C00_0000);
        sif.inst_sram_req = 1'b0; sif.bus_addr_ok = 1'b0;
        run_cycle();
        sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h0280_0C0C;
        run_cycle();
        check("s1_inst_dok", 128'(obs_inst_dok), 128'd1);
        check("s1_rdata", 128'(obs_inst_rdata), 128'h0280_0C0C);
        check("s1_data_dok", 128'(obs_data_dok), 128'd0);
        idle_inputs();

        // Simultaneous requests: data store wins.
        sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_0004;
        sif.data_sram_req = 1'b1; sif.data_sram_wr = 1'b1; sif.data_sram_size = 2'd1;
        sif.data_sram_addr = 32'h80; sif.data_sram_wstrb = 4'b0011; sif.data_sram_wdata = 32'h1234;
        sif.bus_addr_ok = 1'b1;
        run_cycle();
        check("s2_wstrb", 128'(obs_bus_wstrb), 128'h3);
        check("s2_aok", 128'({obs_inst_aok, obs_data_aok}), 128'b01);
        sif.data_sram_req = 1'b0;
        run_cycle();
        check("s2_inst_aok", 128'(obs_inst_aok), 128'd1);
        idle_inputs();
        sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'hAAAA_0001;
        run_cycle();
        check("s2_resp1", 128'({obs_inst_dok, obs_data_dok}), 128'b01);
        sif.bus_rdata = 32'hAAAA_0002;
        run_cycle();
        check("s2_resp2", 128'({obs_inst_dok, obs_data_dok}), 128'b10);
        idle_inputs();

        // Inst stalled three cycles, data arrives meanwhile.
        sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_0008;
        run_cycle();
        check("s3_addr0", 128'(obs_bus_addr), 128'h1C00_0008);
        sif.data_sram_req = 1'b1; sif.data_sram_addr = 32'h100; sif.data_sram_size = 2'd2;
        run_cycle();
        check("s3_addr1", 128'(obs_bus_addr), 128'h1C00_0008);
        run_cycle();
        check("s3_addr2", 128'(obs_bus_addr), 128'h1C00_0008);
        sif.bus_addr_ok = 1'b1;
        run_cycle();
        check("s3_inst_aok", 128'({obs_inst_aok, obs_data_aok}), 128'b10);
        sif.inst_sram_req = 1'b0;
        run_cycle();
        check("s3_data_aok", 128'(obs_data_aok), 128'd1);
        idle_inputs();
        sif.bus_data_ok = 1'b1;
        run_cycle();
        run_cycle();
        idle_inputs();

        // Full FIFO: third request waits for the first response.
        sif.data_sram_req = 1'b1; sif.data_sram_wr = 1'b1; sif.data_sram_addr = 32'h200;
        sif.data_sram_size = 2'd2; sif.data_sram_wstrb = 4'hF; sif.bus_addr_ok = 1'b1;
        run_cycle();
        sif.data_sram_req = 1'b0; sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_000C;
        run_cycle();
        sif.inst_sram_req = 1'b0;
        sif.data_sram_req = 1'b1; sif.data_sram_wr = 1'b0; sif.data_sram_addr = 32'h204;
        run_cycle();
        check("s4_full_req0", 128'(obs_bus_req), 128'd0);
        run_cycle();
        check("s4_full_req1", 128'(obs_bus_req), 128'd0);
        sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h5555_0001;
        run_cycle();
        check("s4_pop_push", 128'({obs_data_dok, obs_bus_req, obs_data_aok}), 128'b111);
        sif.data_sram_req = 1'b0;
        run_cycle();
        check("s4_inst_resp", 128'({obs_inst_dok, obs_data_dok}), 128'b10);
        run_cycle();
        check("s4_third_resp", 128'({obs_inst_dok, obs_data_dok}), 128'b01);
        idle_inputs();

        // Stray response while empty.
        sif.bus_data_ok = 1'b1;
        run_cycle();
        check("s5_dok", 128'({obs_inst_dok, obs_data_dok}), 128'd0);
        sif.bus_data_ok = 1'b0;
        run_cycle();
        check("s5_count", 128'(obs_count), 128'd0);

        // Reset with two outstanding, then late responses.
        sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_0010;
        sif.data_sram_req = 1'b1; sif.data_sram_addr = 32'h300; sif.bus_addr_ok = 1'b1;
        run_cycle();
        sif.data_sram_req = 1'b0;
        run_cycle();
        idle_inputs();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        sif.bus_data_ok = 1'b1;
        run_cycle();
        check("s6_late0", 128'({obs_inst_dok, obs_data_dok}), 128'd0);
        run_cycle();
        check("s6_late1", 128'({obs_inst_dok, obs_data_dok}), 128'd0);
        sif.bus_data_ok = 1'b0;
        sif.inst_sram_req = 1'b1; sif.inst_sram_addr = 32'h1C00_0014; sif.bus_addr_ok = 1'b1;
        run_cycle();
        check("s6_inst_aok", 128'(obs_inst_aok), 128'd1);
        idle_inputs();
        sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'hCAFE_0014;
        run_cycle();
        check("s6_inst_dok", 128'({obs_inst_dok, obs_inst_rdata}), 128'({1'b1, 32'hCAFE_0014}));
        idle_inputs();

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                inst_busy = 1'b0;
                data_busy = 1'b0;
                sif.inst_sram_req = 1'b0;
                sif.data_sram_req = 1'b0;
            end else begin
                reset = 1'b0;
                if (!inst_busy) begin
                    sif.inst_sram_req = ($urandom_range(0, 2) == 0);
                    sif.inst_sram_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    inst_busy = sif.inst_sram_req;
                end
                if (!data_busy) begin
                    sif.data_sram_req   = ($urandom_range(0, 2) == 0);
                    sif.data_sram_wr    = 1'($urandom_range(0, 1));
                    sif.data_sram_size  = 2'($urandom_range(0, 2));
                    sif.data_sram_addr  = $urandom;
                    sif.data_sram_wstrb = 4'($urandom_range(0, 15));
                    sif.data_sram_wdata = $urandom;
                    data_busy = sif.data_sram_req;
                end
            end
            sif.bus_addr_ok = ($urandom_range(0, 99) < 60);
            sif.bus_data_ok = ($urandom_range(0, 99) < 45);
            sif.bus_rdata   = $urandom;
            run_cycle();
            if (inst_acc) begin
                inst_busy = 1'b0;
                sif.inst_sram_req = 1'b0;
            end
            if (data_acc) begin
                data_busy = 1'b0;
                sif.data_sram_req = 1'b0;
            end
        end
        reset = 1'b0;

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
